dmem_port: RTL and testbench
============================

DMEM_PORT -- requirements
Module: dmem_port

Interface
REQ-001 The module SHALL have one parameter: ADDR_WIDTH, default 12, byte-address bits of storage (2^ADDR_WIDTH bytes).
REQ-002 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 req_write  input  1  1 = store (MemWrite), 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_width  input  2  0 = byte, 1 = half, 2 = word, 3 = treated as word (WordWidth).
REQ-010 req_sign_ext  input  1  1 = sign-extend load, 0 = zero-extend (LoadSignExt).
REQ-011 req_wdata  input  32  store data; low 1/2/4 bytes used.
REQ-012 rsp_valid  output  1  one-cycle completion pulse, loads and stores.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores.
REQ-014 rsp_misaligned  output  1  valid with rsp_valid; misaligned access flag.

Function
REQ-015 The module SHALL store 2^ADDR_WIDTH bytes little-endian; effective address = req_addr mod 2^ADDR_WIDTH, each byte address wrapping independently.
REQ-016 The module SHALL register all request fields on acceptance (req_valid && req_ready); inputs are don't-care otherwise.
REQ-017 The FSM SHALL have states IDLE, SECOND, RESP; req_ready = 1 in IDLE and RESP, 0 in SECOND.
REQ-018 An accepted access SHALL be aligned when: byte, half with addr[0]=0, or word with addr[1:0]=0.
REQ-019 An aligned accept SHALL go to RESP; the store SHALL be committed at the accepting clock edge, and rsp_valid SHALL be high in the following cycle (latency 1).
REQ-020 A request accepted in RESP SHALL be handled exactly as from IDLE, giving one access per cycle for aligned back-to-back traffic.
REQ-021 RESP with no new accept SHALL return to IDLE.
REQ-022 Loads SHALL return bits [7:0] or [15:0] extended per registered sign_ext; word loads ignore sign_ext.
REQ-023 rsp_misaligned SHALL be 0 for every aligned access.
REQ-024 The FSM SHALL clear rsp_valid, rsp_rdata and rsp_misaligned to 0 in cycles without a response.
REQ-025 A load of a location stored in the immediately preceding accepted request SHALL return the new data (no stale read).

Reset
REQ-026 rst SHALL force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, immediately and independent of clk.
REQ-027 Reset in SECOND SHALL abandon the access: bytes of the second word not yet written stay unwritten; no response is issued.
REQ-028 Reset SHALL NOT clear storage contents.

Configuration
REQ-029 With DMEM_MISALIGN_SPLIT_EN defined, a misaligned accept SHALL enter SECOND, then RESP.
REQ-030 With the macro defined, the bytes in the lower word SHALL be handled at the accept edge and the bytes in the next word at the SECOND edge.
REQ-031 With the macro defined, rsp_valid SHALL arrive 2 cycles after accept, with full data and rsp_misaligned=1.
REQ-032 With the macro undefined, a misaligned accept SHALL go to RESP without writing storage.
REQ-033 With the macro undefined, the response SHALL be rsp_valid=1, rsp_rdata=0, rsp_misaligned=1; SECOND is unreachable.

Verification
REQ-034 Store word 0xDEADBEEF @0x10, then load byte sign_ext=1 @0x13 -> rsp_rdata=0xFFFFFFDE; load half sign_ext=0 @0x12 -> 0x0000DEAD.
REQ-035 Aligned store/load back-to-back for 4 cycles with req_valid held high -> req_ready stays 1 and rsp_valid=1 on every cycle after the first.
REQ-036 Split on: store word 0x11223344 @0x0E, then load word @0x0E -> 0x11223344, rsp_misaligned=1, rsp_valid 2 cycles after accept, req_ready=0 in SECOND.
REQ-037 Split off: the same store -> rsp_misaligned=1; aligned loads @0x0C and @0x10 return their prior values.
REQ-038 ADDR_WIDTH=12, split on: store word 0xAABBCCDD @0xFFE -> load half @0xFFE = 0xCCDD and load half @0x000 = 0xAABB (wrap).
REQ-039 Split on: assert rst during SECOND of a store word @0x0E -> outputs reset immediately, no rsp_valid, and the word @0x10 is unchanged.

Source files
------------

// File: rtl/dmem_port_if.sv
// Request/response bundle for the data-memory port.
// master drives requests; slave (dmem_port) answers.
interface dmem_port_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_width;
   logic        req_sign_ext;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_misaligned;

   modport master (
      output req_valid, req_write, req_addr, req_width,
      output req_sign_ext, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_width,
      input  req_sign_ext, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_misaligned
   );
endinterface

// File: rtl/dmem_port.sv
// Byte-addressed little-endian data memory port, 1-cycle latency.
// Define DMEM_MISALIGN_SPLIT_EN to split misaligned accesses over two cycles.
module dmem_port #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic        clk,
   input  logic        rst,
   dmem_port_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SECOND = 2'd1,
      RESP   = 2'd2
   } state_t;

`ifdef DMEM_MISALIGN_SPLIT_EN
   localparam logic SPLIT = 1'b1;
`else
   localparam logic SPLIT = 1'b0;
`endif

   state_t                r_state;
   logic [7:0]            r_mem [1<<ADDR_WIDTH];
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_width;
   logic                  r_sext;
   logic [31:0]           r_wdata;
   logic [31:0]           r_rbuf;
   logic                  r_rsp_valid;
   logic [31:0]           r_rsp_rdata;
   logic                  r_rsp_mis;

   logic                  w_acc;
   logic                  w_phase2;
   logic                  w_write;
   logic                  w_sext;
   logic                  w_aligned;
   logic                  w_store_en;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [1:0]            w_width;
   logic [31:0]           w_wdata;
   logic [2:0]            w_nbytes;
   logic [2:0]            w_off;
   logic [3:0]            w_lane;
   logic [ADDR_WIDTH-1:0] w_baddr [4];
   logic [31:0]           w_raw;
   logic [31:0]           w_ext;
   logic                  w_unused;

   assign bus.req_ready      = (r_state != SECOND);
   assign bus.rsp_valid      = r_rsp_valid;
   assign bus.rsp_rdata      = r_rsp_rdata;
   assign bus.rsp_misaligned = r_rsp_mis;

   assign w_acc    = bus.req_valid && bus.req_ready;
   assign w_phase2 = (r_state == SECOND);
   assign w_unused = &{1'b0, bus.req_addr[31:ADDR_WIDTH]};

   // In SECOND the held request drives the datapath, otherwise the live one.
   assign w_write = w_phase2 ? r_write : bus.req_write;
   assign w_addr  = w_phase2 ? r_addr  : bus.req_addr[ADDR_WIDTH-1:0];
   assign w_width = w_phase2 ? r_width : bus.req_width;
   assign w_sext  = w_phase2 ? r_sext  : bus.req_sign_ext;
   assign w_wdata = w_phase2 ? r_wdata : bus.req_wdata;

   // Access size and alignment of the selected request.
   always_comb begin
      w_nbytes  = 3'd4;
      w_aligned = (w_addr[1:0] == 2'b00);
      case (w_width)
         2'd0: begin
            w_nbytes  = 3'd1;
            w_aligned = 1'b1;
         end
         2'd1: begin
            w_nbytes  = 3'd2;
            w_aligned = ~w_addr[0];
         end
         default: ;
      endcase
   end

   // Lane k is live in this phase when its byte falls in the current word.
   always_comb begin
      w_lane = 4'b0000;
      w_off  = 3'd0;
      w_raw  = 32'h0;
      for (int k = 0; k < 4; k++) begin
         w_off      = {1'b0, w_addr[1:0]} + 3'(k);
         w_baddr[k] = w_addr + ADDR_WIDTH'(k);
         w_lane[k]  = (3'(k) < w_nbytes) && (w_phase2 == w_off[2]);
         if (w_lane[k])
            w_raw[8*k +: 8] = r_mem[w_baddr[k]];
         else if (w_phase2)
            w_raw[8*k +: 8] = r_rbuf[8*k +: 8];
      end
   end

   // Extend the assembled load bytes to 32 bits.
   always_comb begin
      w_ext = w_raw;
      case (w_width)
         2'd0: w_ext = {{24{w_sext & w_raw[7]}}, w_raw[7:0]};
         2'd1: w_ext = {{16{w_sext & w_raw[15]}}, w_raw[15:0]};
         default: ;
      endcase
   end

   // A misaligned store without splitting never touches storage; reset
   // blocks the second-word write of an abandoned split.
   assign w_store_en = w_write && !rst &&
                       (w_phase2 || (w_acc && (w_aligned || SPLIT)));

   // Byte-lane writes into storage; storage is not reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (w_store_en && w_lane[k])
            r_mem[w_baddr[k]] <= w_wdata[8*k +: 8];
      end
   end

   // Control FSM with registered response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_width     <= 2'd0;
         r_sext      <= 1'b0;
         r_wdata     <= 32'h0;
         r_rbuf      <= 32'h0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_mis   <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_mis   <= 1'b0;
         case (r_state)
            SECOND: begin
               r_state     <= RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_mis   <= 1'b1;
               r_rsp_rdata <= r_write ? 32'h0 : w_ext;
            end
            default: begin
               r_state <= IDLE;
               if (w_acc) begin
                  r_write <= bus.req_write;
                  r_addr  <= bus.req_addr[ADDR_WIDTH-1:0];
                  r_width <= bus.req_width;
                  r_sext  <= bus.req_sign_ext;
                  r_wdata <= bus.req_wdata;
                  r_rbuf  <= w_raw;
                  if (w_aligned) begin
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_rdata <= bus.req_write ? 32'h0 : w_ext;
                  end else begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                     r_state     <= SECOND;
`else
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_mis   <= 1'b1;
`endif
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port.sv
// Directed scoreboard bench for dmem_port (ADDR_WIDTH=12).
// Split-specific steps follow DMEM_MISALIGN_SPLIT_EN.
module tb_dmem_port;

   logic clk = 1'b0;
   logic rst = 1'b1;

   dmem_port_if bus ();

   dmem_port #(.ADDR_WIDTH(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      string       tag;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   checks = 0;
   int   errors = 0;
   logic last_ready;
   logic last_rspv;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Response monitor: pops the scoreboard on every response pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rsp_valid === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
               errors++;
               $error("FAIL unexpected_rsp observed=%h expected=none",
                      bus.rsp_rdata);
            end
            if (sb.size() > 0) begin
               m_e = sb.pop_front();
               chk({m_e.tag, "_rdata"}, bus.rsp_rdata, m_e.rdata);
               chk({m_e.tag, "_mis"}, 32'(bus.rsp_misaligned),
                   32'(m_e.mis));
            end
         end else begin
            chk("idle_rdata", bus.rsp_rdata, 32'h0);
            chk("idle_mis", 32'(bus.rsp_misaligned), 32'h0);
         end
      end
   end

   task automatic req(input string tag, input bit wr,
                      input logic [31:0] addr, input logic [1:0] w,
                      input bit sx, input logic [31:0] wd,
                      input logic [31:0] er, input bit em, input bit push);
      int n;
      bus.req_valid    = 1'b1;
      bus.req_write    = wr;
      bus.req_addr     = addr;
      bus.req_width    = w;
      bus.req_sign_ext = sx;
      bus.req_wdata    = wd;
      n = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (n < 20) else begin
         errors++;
         $error("FAIL %s_accept observed=%0d expected=<20", tag, n);
      end
      last_ready = bus.req_ready;
      last_rspv  = bus.rsp_valid;
      if (push) sb.push_back('{er, em, tag});
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.req_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_width    = 2'd0;
      bus.req_sign_ext = 1'b0;
      bus.req_wdata    = 32'h0;

      #2;
      chk("rst_ready", 32'(bus.req_ready), 32'h1);
      chk("rst_rspv", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_mis", 32'(bus.rsp_misaligned), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(1);

      // Basic store / loads with extension.
      req("st10", 1, 32'h10, 2, 0, 32'hDEADBEEF, 32'h0, 0, 1);
      idle(1);
      req("lb13s", 0, 32'h13, 0, 1, 32'h0, 32'hFFFFFFDE, 0, 1);
      req("lh12z", 0, 32'h12, 1, 0, 32'h0, 32'h0000DEAD, 0, 1);
      req("lh12s", 0, 32'h12, 1, 1, 32'h0, 32'hFFFFDEAD, 0, 1);
      req("lb10z", 0, 32'h10, 0, 0, 32'h0, 32'h000000EF, 0, 1);
      req("lw3", 0, 32'h10, 3, 1, 32'h0, 32'hDEADBEEF, 0, 1);
      req("st0c", 1, 32'h0C, 2, 0, 32'h01020304, 32'h0, 0, 1);
      req("lw0c", 0, 32'h0C, 2, 0, 32'h0, 32'h01020304, 0, 1);
      idle(2);

      // Back-to-back aligned traffic.
      req("bb0", 1, 32'h20, 2, 0, 32'hCAFEF00D, 32'h0, 0, 1);
      chk("bb0_ready", 32'(last_ready), 32'h1);
      req("bb1", 0, 32'h20, 2, 0, 32'h0, 32'hCAFEF00D, 0, 1);
      chk("bb1_ready", 32'(last_ready), 32'h1);
      chk("bb1_rspv", 32'(last_rspv), 32'h1);
      req("bb2", 1, 32'h24, 1, 0, 32'h00001234, 32'h0, 0, 1);
      chk("bb2_ready", 32'(last_ready), 32'h1);
      chk("bb2_rspv", 32'(last_rspv), 32'h1);
      req("bb3", 0, 32'h24, 1, 1, 32'h0, 32'h00001234, 0, 1);
      chk("bb3_ready", 32'(last_ready), 32'h1);
      chk("bb3_rspv", 32'(last_rspv), 32'h1);
      @(negedge clk);
      chk("bb4_rspv", 32'(bus.rsp_valid), 32'h1);
      chk("bb4_ready", 32'(bus.req_ready), 32'h1);
      idle(2);

`ifdef DMEM_MISALIGN_SPLIT_EN
      // Split misaligned store, then read back across the word boundary.
      req("sp_st", 1, 32'h0E, 2, 0, 32'h11223344, 32'h0, 1, 1);
      @(negedge clk);
      chk("sp_second_ready", 32'(bus.req_ready), 32'h0);
      chk("sp_second_rspv", 32'(bus.rsp_valid), 32'h0);
      @(negedge clk);
      chk("sp_lat2_rspv", 32'(bus.rsp_valid), 32'h1);
      idle(1);
      req("sp_lw", 0, 32'h0E, 2, 0, 32'h0, 32'h11223344, 1, 1);
      idle(2);
      req("sp_lh0f", 0, 32'h0F, 1, 1, 32'h0, 32'h00002233, 1, 1);
      idle(2);

      // Address wrap at the top of storage.
      req("wr_st", 1, 32'hFFE, 2, 0, 32'hAABBCCDD, 32'h0, 1, 1);
      idle(2);
      req("wr_lhffe", 0, 32'hFFE, 1, 0, 32'h0, 32'h0000CCDD, 0, 1);
      req("wr_lh000", 0, 32'h000, 1, 0, 32'h0, 32'h0000AABB, 0, 1);
      req("wr_lhali", 0, 32'h1000, 1, 0, 32'h0, 32'h0000AABB, 0, 1);
      idle(2);

      // Reset during SECOND abandons the upper-word bytes.
      req("ab_st", 1, 32'h0E, 2, 0, 32'h99AABBCC, 32'h0, 1, 0);
      #2 rst = 1'b1;
      #1;
      chk("ab_ready", 32'(bus.req_ready), 32'h1);
      chk("ab_rspv", 32'(bus.rsp_valid), 32'h0);
      chk("ab_rdata", bus.rsp_rdata, 32'h0);
      chk("ab_mis", 32'(bus.rsp_misaligned), 32'h0);
      @(posedge clk);
      #3 rst = 1'b0;
      idle(2);
      req("ab_lw10", 0, 32'h10, 2, 0, 32'h0, 32'hDEAD1122, 0, 1);
      req("ab_lw0c", 0, 32'h0C, 2, 0, 32'h0, 32'hBBCC0304, 0, 1);
      idle(2);
`else
      // Misaligned accesses are flagged and leave storage untouched.
      req("ms_st", 1, 32'h0E, 2, 0, 32'h11223344, 32'h0, 1, 1);
      @(negedge clk);
      chk("ms_lat1_rspv", 32'(bus.rsp_valid), 32'h1);
      chk("ms_ready", 32'(bus.req_ready), 32'h1);
      idle(1);
      req("ms_lw0c", 0, 32'h0C, 2, 0, 32'h0, 32'h01020304, 0, 1);
      req("ms_lw10", 0, 32'h10, 2, 0, 32'h0, 32'hDEADBEEF, 0, 1);
      req("ms_lh11", 0, 32'h11, 1, 1, 32'h0, 32'h0, 1, 1);
      req("ms_lw12", 0, 32'h12, 2, 0, 32'h0, 32'h0, 1, 1);
      idle(2);
`endif

      idle(3);
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain observed=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
